// File: rtl/interconnect_two_data_to_sfft.sv
// Merges a buffered first half-frame ("chet") with a pass-through second half ("Nchet")
// into one valid/ready sample stream for the streaming FFT core.
module interconnect_two_data_to_sfft #(
    parameter int unsigned SIZE_BUFFER   = 1,
    parameter int unsigned DATA_FFT_SIZE = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_valid_chet,
    input  logic [DATA_FFT_SIZE-1:0] i_data_chet_i,
    input  logic [DATA_FFT_SIZE-1:0] i_data_chet_q,
    output logic                     o_ready_chet,
    input  logic                     i_valid_Nchet,
    input  logic [DATA_FFT_SIZE-1:0] i_data_Nchet_i,
    input  logic [DATA_FFT_SIZE-1:0] i_data_Nchet_q,
    output logic                     o_ready_Nchet,
    output logic                     o_fft_valid,
    output logic [DATA_FFT_SIZE-1:0] o_data_to_fft_i,
    output logic [DATA_FFT_SIZE-1:0] o_data_to_fft_q,
    input  logic                     i_fft_ready,
    output logic                     o_fft_last,
    output logic                     o_frame_done
);

    localparam int unsigned HALF = 1 << (SIZE_BUFFER - 1);
    localparam int unsigned CW   = (SIZE_BUFFER > 1) ? SIZE_BUFFER - 1 : 1;
    localparam int unsigned DW   = 2 * DATA_FFT_SIZE;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    typedef enum logic [1:0] {StWaitBuf, StSendBuf, StPass} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CW-1:0] pass_cnt_q, pass_cnt_d;
    logic          buf_full_q, buf_full_d;
    logic          frame_done_q, frame_done_d;
    logic [DW-1:0] buf_mem [HALF];
    logic          chet_xfer;

    assign o_ready_chet = !buf_full_q;
    assign chet_xfer    = i_valid_chet && !buf_full_q;
    assign o_frame_done = frame_done_q;

    // Sample storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (chet_xfer) begin
            buf_mem[wr_cnt_q] <= {i_data_chet_i, i_data_chet_q};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= StWaitBuf;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            pass_cnt_q   <= '0;
            buf_full_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            buf_full_q   <= buf_full_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wr_cnt_d        = wr_cnt_q;
        rd_cnt_d        = rd_cnt_q;
        pass_cnt_d      = pass_cnt_q;
        buf_full_d      = buf_full_q;
        frame_done_d    = 1'b0;
        o_fft_valid     = 1'b0;
        o_ready_Nchet   = 1'b0;
        o_fft_last      = 1'b0;
        o_data_to_fft_i = '0;
        o_data_to_fft_q = '0;

        // Writer runs independently; it can never collide with the release below
        // because writes are blocked while the buffer is full.
        if (chet_xfer) begin
            if (wr_cnt_q == CNT_LAST) begin
                wr_cnt_d   = '0;
                buf_full_d = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + CW'(1);
            end
        end

        case (state_q)
            StWaitBuf: begin
                if (buf_full_q) begin
                    state_d = StSendBuf;
                end
            end
            StSendBuf: begin
                o_fft_valid                        = 1'b1;
                {o_data_to_fft_i, o_data_to_fft_q} = buf_mem[rd_cnt_q];
                if (i_fft_ready) begin
                    if (rd_cnt_q == CNT_LAST) begin
                        rd_cnt_d   = '0;
                        buf_full_d = 1'b0;
                        state_d    = StPass;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CW'(1);
                    end
                end
            end
            StPass: begin
                o_fft_valid     = i_valid_Nchet;
                o_data_to_fft_i = i_data_Nchet_i;
                o_data_to_fft_q = i_data_Nchet_q;
                o_ready_Nchet   = i_fft_ready;
                o_fft_last      = (pass_cnt_q == CNT_LAST);
                if (i_valid_Nchet && i_fft_ready) begin
                    if (pass_cnt_q == CNT_LAST) begin
                        pass_cnt_d   = '0;
                        frame_done_d = 1'b1;
                        // A refilled buffer starts the next frame with no bubble.
                        state_d      = buf_full_q ? StSendBuf : StWaitBuf;
                    end else begin
                        pass_cnt_d = pass_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = StWaitBuf;
            end
        endcase
    end

endmodule

// File: tb/tb_interconnect_two_data_to_sfft.sv
// Bench: queue-based frame scoreboard for the half-frame merger, NFFT=8 and NFFT=2 instances.
`timescale 1ns/1ps
module tb_interconnect_two_data_to_sfft;

    localparam int unsigned DW = 16;
    localparam int HALF_A = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   rdy_mode;
    bit   abort;

    logic a_vc, a_rc, a_vn, a_rn, a_fv, a_fr, a_last, a_done;
    logic [DW-1:0] a_ci, a_cq, a_ni, a_nq, a_fi, a_fq;
    logic b_vc, b_rc, b_vn, b_rn, b_fv, b_fr, b_last, b_done;
    logic [DW-1:0] b_ci, b_cq, b_ni, b_nq, b_fi, b_fq;

    logic [31:0] obs_d[$];
    bit          obs_last[$];
    int          obs_cyc[$];
    int          last_cyc[$];
    int          done_cyc[$];
    int          chet_cyc[$];
    int          stall_err;
    bit          stall_prev;
    logic [31:0] stall_data;

    interconnect_two_data_to_sfft #(.SIZE_BUFFER(3), .DATA_FFT_SIZE(DW)) u_dut_a (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_valid_chet(a_vc), .i_data_chet_i(a_ci), .i_data_chet_q(a_cq), .o_ready_chet(a_rc),
        .i_valid_Nchet(a_vn), .i_data_Nchet_i(a_ni), .i_data_Nchet_q(a_nq),
        .o_ready_Nchet(a_rn), .o_fft_valid(a_fv), .o_data_to_fft_i(a_fi),
        .o_data_to_fft_q(a_fq), .i_fft_ready(a_fr), .o_fft_last(a_last), .o_frame_done(a_done)
    );

    interconnect_two_data_to_sfft #(.SIZE_BUFFER(1), .DATA_FFT_SIZE(DW)) u_dut_b (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_valid_chet(b_vc), .i_data_chet_i(b_ci), .i_data_chet_q(b_cq), .o_ready_chet(b_rc),
        .i_valid_Nchet(b_vn), .i_data_Nchet_i(b_ni), .i_data_Nchet_q(b_nq),
        .o_ready_Nchet(b_rn), .o_fft_valid(b_fv), .o_data_to_fft_i(b_fi),
        .o_data_to_fft_q(b_fq), .i_fft_ready(b_fr), .o_fft_last(b_last), .o_frame_done(b_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        a_fr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       a_fr = 1'b1;
                1:       a_fr = ~a_fr;
                default: a_fr = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Recorder for instance A: the negedge value is what the next rising edge transfers.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && (!a_fv || {a_fi, a_fq} != stall_data)) stall_err++;
                if (a_fv && a_fr) begin
                    obs_d.push_back({a_fi, a_fq});
                    obs_last.push_back(a_last);
                    obs_cyc.push_back(cyc);
                    if (a_last) last_cyc.push_back(cyc);
                end
                if (a_done) done_cyc.push_back(cyc);
                stall_prev = a_fv && !a_fr;
                stall_data = {a_fi, a_fq};
            end
        end
    end

    function automatic logic [31:0] mk(input int k);
        return {k[15:0], k[15:0] ^ 16'hA5A5};
    endfunction

    task automatic clear_obs();
        obs_d.delete(); obs_last.delete(); obs_cyc.delete();
        last_cyc.delete(); done_cyc.delete(); chet_cyc.delete();
        stall_err = 0; stall_prev = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; abort = 1'b0;
        a_vc = 1'b0; a_ci = '0; a_cq = '0; a_vn = 1'b0; a_ni = '0; a_nq = '0;
        b_vc = 1'b0; b_ci = '0; b_cq = '0; b_vn = 1'b0; b_ni = '0; b_nq = '0; b_fr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear_obs();
        rst_n = 1'b1;
    endtask

    task automatic drive_chet(input logic [31:0] s[$], input int g[$]);
        bit ok;
        int n;
        for (int k = 0; k < s.size(); k++) begin
            if (g[k] > 0) begin
                a_vc = 1'b0;
                repeat (g[k]) begin @(posedge clk); #1; end
            end
            a_vc = 1'b1;
            {a_ci, a_cq} = s[k];
            ok = 1'b0; n = 0;
            while (!ok) begin
                @(negedge clk);
                ok = a_rc && rst_n;
                if (ok) chet_cyc.push_back(cyc);
                @(posedge clk);
                #1;
                if (abort || n > 1500) begin a_vc = 1'b0; return; end
                n++;
            end
        end
        a_vc = 1'b0;
    endtask

    task automatic drive_nchet(input logic [31:0] s[$], input int g[$]);
        bit ok;
        int n;
        for (int k = 0; k < s.size(); k++) begin
            if (g[k] > 0) begin
                a_vn = 1'b0;
                repeat (g[k]) begin @(posedge clk); #1; end
            end
            a_vn = 1'b1;
            {a_ni, a_nq} = s[k];
            ok = 1'b0; n = 0;
            while (!ok) begin
                @(negedge clk);
                ok = a_vn && a_rn && rst_n;
                @(posedge clk);
                #1;
                if (abort || n > 1500) begin a_vn = 1'b0; return; end
                n++;
            end
        end
        a_vn = 1'b0;
    endtask

    task automatic run_traffic(input logic [31:0] cq[$], input int cg[$],
                               input logic [31:0] nq[$], input int ng[$], input int nexp);
        int k;
        fork
            drive_chet(cq, cg);
            drive_nchet(nq, ng);
        join
        k = 0;
        while (obs_d.size() < nexp && k < 3000) begin @(posedge clk); k++; end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Expected FFT order: each frame is its chet half followed by its Nchet half.
    task automatic build_exp(input logic [31:0] cq[$], input logic [31:0] nq[$],
                             output logic [31:0] e[$]);
        e.delete();
        for (int f = 0; f < cq.size() / HALF_A; f++) begin
            for (int j = 0; j < HALF_A; j++) e.push_back(cq[f * HALF_A + j]);
            for (int j = 0; j < HALF_A; j++) e.push_back(nq[f * HALF_A + j]);
        end
    endtask

    task automatic test_reset();
        rdy_mode = 0;
        do_reset();
        rst_n = 1'b0;
        a_vn = 1'b1; {a_ni, a_nq} = mk(99);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({a_rc, a_rn, a_fv, a_last, a_done, a_fi, a_fq} !== {1'b1, 4'b0, 32'b0}) begin
            n_fail++;
            $display("FAIL reset_a: got rc=%b rn=%b v=%b last=%b done=%b d=%h, expected 1 0 0 0 0 0",
                     a_rc, a_rn, a_fv, a_last, a_done, {a_fi, a_fq});
        end
        n_tests++;
        if ({b_rc, b_rn, b_fv, b_last, b_done, b_fi, b_fq} !== {1'b1, 4'b0, 32'b0}) begin
            n_fail++;
            $display("FAIL reset_b: got rc=%b rn=%b v=%b last=%b done=%b d=%h, expected 1 0 0 0 0 0",
                     b_rc, b_rn, b_fv, b_last, b_done, {b_fi, b_fq});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic(input int mode, input string nm);
        logic [31:0] cq[$], nq[$], e[$];
        int cg[$], ng[$];
        rdy_mode = mode;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            cq.push_back(mk(k)); nq.push_back(mk(k + 4)); cg.push_back(0); ng.push_back(0);
        end
        build_exp(cq, nq, e);
        run_traffic(cq, cg, nq, ng, e.size());
        n_tests++;
        if (obs_d.size() !== e.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d samples, expected %0d", nm, obs_d.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < obs_d.size(); i++) begin
            n_tests++;
            if (obs_d[i] !== e[i] || obs_last[i] !== (i % 8 == 7)) begin
                n_fail++;
                $display("FAIL %s_seq[%0d]: got %h last=%0b, expected %h last=%0b",
                         nm, i, obs_d[i], obs_last[i], e[i], (i % 8 == 7));
            end
        end
        n_tests++;
        if (done_cyc.size() !== 1 || last_cyc.size() !== 1 || done_cyc[0] !== last_cyc[0] + 1) begin
            n_fail++;
            $display("FAIL %s_done: got %0d pulses, expected 1 pulse the cycle after last", nm,
                     done_cyc.size());
        end
        n_tests++;
        if (stall_err !== 0) begin
            n_fail++;
            $display("FAIL %s_stable: got %0d changes under stall, expected 0", nm, stall_err);
        end
        if (mode == 0) begin
            n_tests++;
            if (obs_cyc.size() < 8 || chet_cyc.size() < 4 || obs_cyc[0] !== chet_cyc[3] + 2 ||
                obs_cyc[7] !== obs_cyc[0] + 7) begin
                n_fail++;
                $display("FAIL %s_latency: first/last out at %0d/%0d, last write %0d, expected %0d/%0d",
                         nm, (obs_cyc.size() > 0) ? obs_cyc[0] : -1,
                         (obs_cyc.size() > 7) ? obs_cyc[7] : -1,
                         (chet_cyc.size() > 3) ? chet_cyc[3] : -1,
                         (chet_cyc.size() > 3) ? chet_cyc[3] + 2 : -1,
                         (chet_cyc.size() > 3) ? chet_cyc[3] + 9 : -1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] cq[$], nq[$], e[$];
        int cg[$], ng[$];
        int base[3] = '{1, 11, 41};
        rdy_mode = 0;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 4; j++) begin
                cq.push_back(mk(base[f] + j)); nq.push_back(mk(base[f] + 4 + j));
                cg.push_back(0); ng.push_back((f == 0 && j == 3) ? 2 : 0);
            end
        end
        build_exp(cq, nq, e);
        run_traffic(cq, cg, nq, ng, e.size());
        n_tests++;
        if (obs_d.size() !== e.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d samples, expected %0d", obs_d.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < obs_d.size(); i++) begin
            n_tests++;
            if (obs_d[i] !== e[i] || obs_last[i] !== (i % 8 == 7)) begin
                n_fail++;
                $display("FAIL b2b_seq[%0d]: got %h last=%0b, expected %h last=%0b",
                         i, obs_d[i], obs_last[i], e[i], (i % 8 == 7));
            end
        end
        n_tests++;
        if (obs_cyc.size() < 12 || obs_cyc[8] !== obs_cyc[7] + 1 || obs_cyc[11] !== obs_cyc[7] + 4)
        begin
            n_fail++;
            $display("FAIL b2b_nobubble: got %0d samples or gap after sample 8, expected 11..14 right after 8",
                     obs_cyc.size());
        end
        n_tests++;
        if (chet_cyc.size() < 9 || obs_cyc.size() < 12 || chet_cyc[8] !== obs_cyc[11] + 1) begin
            n_fail++;
            $display("FAIL b2b_ready_chet: next write at %0d, expected %0d",
                     (chet_cyc.size() > 8) ? chet_cyc[8] : -1,
                     (obs_cyc.size() > 11) ? obs_cyc[11] + 1 : -1);
        end
        n_tests++;
        if (done_cyc.size() !== 3) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d pulses, expected 3", done_cyc.size());
        end
    endtask

    task automatic test_nchet_early();
        logic [31:0] cq[$], nq[$], e[$];
        int cg[$], ng[$];
        rdy_mode = 0;
        do_reset();
        rst_n = 1'b0;
        a_vn = 1'b1; {a_ni, a_nq} = mk(5);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tests++;
            if (a_rn !== 1'b0 || a_fv !== 1'b0) begin
                n_fail++;
                $display("FAIL early_idle[%0d]: got ready_nchet=%b valid=%b, expected 0 0", c, a_rn, a_fv);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 1; k <= 4; k++) begin
            cq.push_back(mk(k)); nq.push_back(mk(k + 4)); cg.push_back(0); ng.push_back(0);
        end
        build_exp(cq, nq, e);
        run_traffic(cq, cg, nq, ng, e.size());
        n_tests++;
        if (obs_d.size() !== e.size()) begin
            n_fail++;
            $display("FAIL early_count: got %0d samples, expected %0d", obs_d.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < obs_d.size(); i++) begin
            n_tests++;
            if (obs_d[i] !== e[i]) begin
                n_fail++;
                $display("FAIL early_seq[%0d]: got %h, expected %h", i, obs_d[i], e[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] cq[$], nq[$], e[$];
        int cg[$], ng[$];
        int k;
        rdy_mode = 0;
        do_reset();
        for (int j = 1; j <= 4; j++) begin
            cq.push_back(mk(j)); nq.push_back(mk(j + 4)); cg.push_back(0); ng.push_back(0);
        end
        cq.push_back(mk(31)); cg.push_back(0);
        cq.push_back(mk(32)); cg.push_back(0);
        fork
            drive_chet(cq, cg);
            drive_nchet(nq, ng);
            begin
                k = 0;
                while (obs_d.size() < 6 && k < 500) begin @(posedge clk); k++; end
                #2;
                rst_n = 1'b0; abort = 1'b1;
                #1;
                n_tests++;
                if ({a_rc, a_rn, a_fv, a_last, a_done, a_fi, a_fq} !== {1'b1, 4'b0, 32'b0}) begin
                    n_fail++;
                    $display("FAIL midreset_outputs: got rc=%b rn=%b v=%b last=%b done=%b d=%h, expected 1 0 0 0 0 0",
                             a_rc, a_rn, a_fv, a_last, a_done, {a_fi, a_fq});
                end
            end
        join
        n_tests++;
        if (obs_d.size() !== 6 || done_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL midreset_abort: got %0d samples, %0d done pulses, expected 6, 0",
                     obs_d.size(), done_cyc.size());
        end
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        clear_obs();
        rst_n = 1'b1;
        cq.delete(); nq.delete(); cg.delete(); ng.delete();
        for (int j = 21; j <= 24; j++) begin
            cq.push_back(mk(j)); nq.push_back(mk(j + 4)); cg.push_back(0); ng.push_back(0);
        end
        build_exp(cq, nq, e);
        run_traffic(cq, cg, nq, ng, e.size());
        n_tests++;
        if (obs_d.size() !== e.size()) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d samples, expected %0d", obs_d.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < obs_d.size(); i++) begin
            n_tests++;
            if (obs_d[i] !== e[i] || obs_last[i] !== (i == 7)) begin
                n_fail++;
                $display("FAIL midreset_seq[%0d]: got %h last=%0b, expected %h last=%0b",
                         i, obs_d[i], obs_last[i], e[i], (i == 7));
            end
        end
        n_tests++;
        if (done_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL midreset_done: got %0d pulses, expected 1", done_cyc.size());
        end
    endtask

    task automatic test_min_size();
        logic [31:0] sa, sb;
        logic [31:0] got[$];
        bit gl[$];
        int nd;
        bit wc, wn;
        rdy_mode = 0;
        do_reset();
        b_fr = 1'b1;
        for (int it = 0; it < 3; it++) begin
            sa = $urandom; sb = $urandom;
            got.delete(); gl.delete(); nd = 0;
            b_vc = 1'b1; {b_ci, b_cq} = sa;
            b_vn = 1'b1; {b_ni, b_nq} = sb;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                wc = b_vc && b_rc;
                wn = b_vn && b_rn;
                if (b_fv && b_fr) begin got.push_back({b_fi, b_fq}); gl.push_back(b_last); end
                if (b_done) nd++;
                @(posedge clk);
                #1;
                if (wc) b_vc = 1'b0;
                if (wn) b_vn = 1'b0;
            end
            n_tests++;
            if (got.size() !== 2) begin
                n_fail++;
                $display("FAIL min_count[%0d]: got %0d samples, expected 2", it, got.size());
            end else begin
                n_tests++;
                if ({got[0], got[1], gl[0], gl[1]} !== {sa, sb, 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL min_seq[%0d]: got %h %h last=%0b%0b, expected %h %h last=01",
                             it, got[0], got[1], gl[0], gl[1], sa, sb);
                end
            end
            n_tests++;
            if (nd !== 1) begin
                n_fail++;
                $display("FAIL min_done[%0d]: got %0d pulses, expected 1", it, nd);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] cq[$], nq[$], e[$];
        int cg[$], ng[$];
        int bad;
        rdy_mode = 2;
        do_reset();
        for (int k = 0; k < 6 * HALF_A; k++) begin
            cq.push_back($urandom); nq.push_back($urandom);
            cg.push_back($urandom_range(0, 3)); ng.push_back($urandom_range(0, 3));
        end
        build_exp(cq, nq, e);
        run_traffic(cq, cg, nq, ng, e.size());
        n_tests++;
        if (obs_d.size() !== e.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d samples, expected %0d", obs_d.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < obs_d.size(); i++) begin
            n_tests++;
            if (obs_d[i] !== e[i] || obs_last[i] !== (i % 8 == 7)) begin
                n_fail++;
                $display("FAIL rand_seq[%0d]: got %h last=%0b, expected %h last=%0b",
                         i, obs_d[i], obs_last[i], e[i], (i % 8 == 7));
            end
        end
        n_tests++;
        if (stall_err !== 0) begin
            n_fail++;
            $display("FAIL rand_stable: got %0d changes under stall, expected 0", stall_err);
        end
        bad = (done_cyc.size() != 6 || last_cyc.size() != 6) ? 1 : 0;
        for (int i = 0; i < done_cyc.size() && i < last_cyc.size(); i++) begin
            if (done_cyc[i] != last_cyc[i] + 1) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rand_done: got %0d pulses (%0d misplaced), expected 6 each one cycle after last",
                     done_cyc.size(), bad);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; rdy_mode = 0; abort = 1'b0;
        stall_err = 0; stall_prev = 1'b0; stall_data = '0;
        rst_n = 1'b0;
        test_reset();
        test_basic(0, "basic");
        test_basic(1, "stall");
        test_back_to_back();
        test_nchet_early();
        test_reset_midframe();
        test_min_size();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
